// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: a one-sector staging buffer that sits between the CPU's
// memory-mapped I/O and an SD controller's byte-level handshake. A read
// command fills the buffer from the card, and a write command drains it to
// the card. The CPU sees the buffer as little-endian 32-bit words.
module sd_sector_buffer #(
  parameter int SECTOR_BYTES   = 512,
  parameter int ADDR_SHIFT     = 9,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cmd_sector,
  input  logic        cmd_read,
  input  logic        cmd_write,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [6:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        sd_ready,
  output logic [31:0] sd_address,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [7:0]  sd_din,
  input  logic        sd_ready_for_next_byte
);

  localparam int WORDS = SECTOR_BYTES / 4;
  localparam int CNT_W = $clog2(SECTOR_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(SECTOR_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, FINISH} state_t;

  state_t            state, next_state, normal_next;
  logic [31:0]       mem [WORDS];
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  din_idx;
  logic [31:0]       din_word;
  logic [TO_W-1:0]   to_cnt;
  logic              bav_q, rfn_q;
  logic              rd_edge, wr_edge;
  logic              progress, timeout_hit, accept;

  // Rising-edge detection of the controller's level handshakes.
  assign rd_edge = sd_byte_available & ~bav_q;
  assign wr_edge = sd_ready_for_next_byte & ~rfn_q;
  assign accept  = (state == IDLE) && sd_ready && (cmd_read || cmd_write);

  // State register.
  // NOTE: every clocked block uses <= so all registers update from the same
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a stall of TIMEOUT_CYCLES clocks overrides the normal path.
  // NOTE: each combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    normal_next = state;
    case (state)
      IDLE: begin
        if (sd_ready && cmd_read)       normal_next = RD_REQ;
        else if (sd_ready && cmd_write) normal_next = WR_REQ;
      end
      RD_REQ:  if (!sd_ready) normal_next = RD_DATA;
      RD_DATA: if (rd_edge && byte_cnt == LAST_BYTE) normal_next = FINISH;
      WR_REQ:  if (!sd_ready) normal_next = WR_DATA;
      WR_DATA: if (wr_edge && byte_cnt == LAST_BYTE) normal_next = FINISH;
      FINISH:  if (sd_ready) normal_next = IDLE;
      default: normal_next = IDLE;
    endcase
    progress    = ((state == RD_DATA) && rd_edge) || ((state == WR_DATA) && wr_edge);
    timeout_hit = (state != IDLE) && (normal_next == state) && !progress && (to_cnt == TO_LAST);
    next_state  = timeout_hit ? IDLE : normal_next;
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == FINISH) && sd_ready;
    sd_rd = (state == RD_REQ);
    sd_wr = (state == WR_REQ);
  end

  // Byte/timeout counters, edge-detect history, command latch and error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt   <= '0;
      to_cnt     <= '0;
      bav_q      <= 1'b0;
      rfn_q      <= 1'b0;
      error      <= 1'b0;
      sd_address <= '0;
    end else begin
      bav_q <= sd_byte_available;
      rfn_q <= sd_ready_for_next_byte;

      if (accept) begin
        sd_address <= cmd_sector << ADDR_SHIFT;
        error      <= 1'b0;
      end else if (timeout_hit) begin
        error <= 1'b1;
      end

      if (accept || (progress && byte_cnt == LAST_BYTE)) byte_cnt <= '0;
      else if (progress)                                  byte_cnt <= byte_cnt + 1'b1;

      if (state == IDLE || next_state != state || progress) to_cnt <= '0;
      else                                                  to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sector store: CPU word writes while idle, card bytes while reading.
  // NOTE: the storage array is deliberately not reset; only the control
  // registers are, so the array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == IDLE && cpu_we)
        mem[cpu_addr] <= cpu_wdata;
      else if (state == RD_DATA && rd_edge)
        mem[byte_cnt[CNT_W-1:2]][{byte_cnt[1:0], 3'b000} +: 8] <= sd_dout;
    end
  end

  // Registered CPU read port, one cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) cpu_rdata <= '0;
    else       cpu_rdata <= mem[cpu_addr];
  end

  // Byte index presented to the card: byte 0 while requesting, next byte on consumption.
  always_comb begin
    din_idx  = (state == WR_DATA) ? byte_cnt + 1'b1 : '0;
    din_word = mem[din_idx[CNT_W-1:2]];
  end

  // Outgoing byte register.
  always_ff @(posedge clock) begin
    if (reset)
      sd_din <= '0;
    else if (state == WR_REQ || (state == WR_DATA && wr_edge))
      sd_din <= din_word[{din_idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer. The bench plays the SD controller,
// keeps a byte-array model of the sector, and checks protocol, data, timeout,
// collision and reset behaviour.
module tb_sd_sector_buffer;

  localparam int SECTOR_BYTES   = 512;
  localparam int ADDR_SHIFT     = 9;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int WORDS          = SECTOR_BYTES / 4;

  logic        clock;
  logic        reset;
  logic [31:0] cmd_sector;
  logic        cmd_read, cmd_write;
  logic        busy, done, error;
  logic [6:0]  cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        sd_ready;
  logic [31:0] sd_address;
  logic        sd_rd, sd_wr;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic [7:0]  sd_din;
  logic        sd_ready_for_next_byte;

  sd_sector_buffer #(
    .SECTOR_BYTES  (SECTOR_BYTES),
    .ADDR_SHIFT    (ADDR_SHIFT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cmd_sector            (cmd_sector),
    .cmd_read              (cmd_read),
    .cmd_write             (cmd_write),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .cpu_addr              (cpu_addr),
    .cpu_we                (cpu_we),
    .cpu_wdata             (cpu_wdata),
    .cpu_rdata             (cpu_rdata),
    .sd_ready              (sd_ready),
    .sd_address            (sd_address),
    .sd_rd                 (sd_rd),
    .sd_wr                 (sd_wr),
    .sd_dout               (sd_dout),
    .sd_byte_available     (sd_byte_available),
    .sd_din                (sd_din),
    .sd_ready_for_next_byte(sd_ready_for_next_byte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  logic [7:0] ref_mem [SECTOR_BYTES];

  // Count every cycle in which done is seen high.
  always @(negedge clock) if (done) done_count++;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
  endfunction

  task automatic cpu_write(input int addr, input logic [31:0] data);
    cpu_addr  = 7'(addr);
    cpu_wdata = data;
    cpu_we    = 1'b1;
    @(negedge clock);
    cpu_we = 1'b0;
    for (int j = 0; j < 4; j++) ref_mem[4*addr+j] = data[8*j +: 8];
  endtask

  task automatic cpu_read(input int addr, output logic [31:0] data);
    cpu_addr = 7'(addr);
    @(negedge clock);
    data = cpu_rdata;
  endtask

  task automatic check_buffer(input string tag);
    int bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      cpu_read(i, w);
      if (w !== ref_word(i)) bad++;
    end
    check({tag, "_bad_words"}, bad, 0);
  endtask

  task automatic start_read(input logic [31:0] sector, input bit both, input string tag);
    logic [31:0] exp_addr;
    exp_addr   = sector << ADDR_SHIFT;
    cmd_sector = sector;
    cmd_read   = 1'b1;
    cmd_write  = both;
    @(negedge clock);
    cmd_read  = 1'b0;
    cmd_write = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_sd_rd"}, sd_rd, 1);
    check({tag, "_sd_wr_quiet"}, sd_wr, 0);
    check({tag, "_sd_address"}, sd_address, exp_addr);
    check({tag, "_error_clear"}, error, 0);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    check({tag, "_sd_rd_held"}, sd_rd, 1);
    sd_ready = 1'b0;
    @(negedge clock);
    check({tag, "_sd_rd_drop"}, sd_rd, 0);
  endtask

  // Controller side of a read; stop_at < SECTOR_BYTES abandons the transfer.
  task automatic xfer_read(input logic [31:0] sector, input bit pattern, input bit both,
                           input bit poke, input int stop_at, input string tag);
    int d0, w, g;
    logic [7:0] b;
    logic [31:0] exp_addr;
    exp_addr = sector << ADDR_SHIFT;
    start_read(sector, both, tag);
    d0 = done_count;
    for (int k = 0; k < stop_at; k++) begin
      b = pattern ? 8'(k) : 8'($urandom);
      w = pattern ? 3 : int'($urandom_range(1, 3));
      g = pattern ? 1 : int'($urandom_range(1, 2));
      ref_mem[k] = b;
      if (k == SECTOR_BYTES - 1) sd_ready = 1'b1;
      sd_dout           = b;
      sd_byte_available = 1'b1;
      @(negedge clock);
      if (k == SECTOR_BYTES - 1) begin
        check({tag, "_done"}, done, 1);
        sd_byte_available = 1'b0;
        @(negedge clock);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulses"}, done_count - d0, 1);
      end else begin
        repeat (w - 1) @(negedge clock);
        sd_byte_available = 1'b0;
        if (poke && k == 100) begin
          sd_ready   = 1'b1;
          cmd_read   = 1'b1;
          cmd_write  = 1'b1;
          cmd_sector = $urandom;
        end
        if (poke && k == 300) begin
          cpu_addr  = 7'd10;
          cpu_wdata = $urandom;
          cpu_we    = 1'b1;
        end
        repeat (g) begin
          @(negedge clock);
          cmd_read  = 1'b0;
          cmd_write = 1'b0;
          cpu_we    = 1'b0;
          if (poke && k == 100) sd_ready = 1'b0;
        end
        if (poke && k == 100) begin
          check({tag, "_busy_cmd_addr"}, sd_address, exp_addr);
          check({tag, "_busy_cmd_busy"}, busy, 1);
        end
      end
    end
  endtask

  // Controller side of a full write, checking every byte presented on sd_din.
  task automatic xfer_write(input logic [31:0] sector, input bit poke, input string tag);
    int d0, bad, w, g;
    logic [31:0] exp_addr;
    exp_addr   = sector << ADDR_SHIFT;
    cmd_sector = sector;
    cmd_write  = 1'b1;
    @(negedge clock);
    cmd_write = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_sd_wr"}, sd_wr, 1);
    check({tag, "_sd_rd_quiet"}, sd_rd, 0);
    check({tag, "_sd_address"}, sd_address, exp_addr);
    @(negedge clock);
    check({tag, "_sd_wr_held"}, sd_wr, 1);
    sd_ready = 1'b0;
    @(negedge clock);
    check({tag, "_sd_wr_drop"}, sd_wr, 0);
    d0  = done_count;
    bad = 0;
    for (int k = 0; k < SECTOR_BYTES; k++) begin
      if (sd_din !== ref_mem[k]) bad++;
      if (k < 4 || k >= SECTOR_BYTES - 4) check($sformatf("%s_din%0d", tag, k), sd_din, ref_mem[k]);
      w = $urandom_range(1, 3);
      g = $urandom_range(1, 2);
      if (k == SECTOR_BYTES - 1) sd_ready = 1'b1;
      sd_ready_for_next_byte = 1'b1;
      if (poke && k == 256) begin
        sd_ready  = 1'b1;
        cmd_read  = 1'b1;
        cpu_addr  = 7'd127;
        cpu_wdata = $urandom;
        cpu_we    = 1'b1;
      end
      @(negedge clock);
      cmd_read = 1'b0;
      cpu_we   = 1'b0;
      if (poke && k == 256) sd_ready = 1'b0;
      if (k == SECTOR_BYTES - 1) begin
        check({tag, "_done"}, done, 1);
        sd_ready_for_next_byte = 1'b0;
        @(negedge clock);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
      end else begin
        repeat (w - 1) @(negedge clock);
        sd_ready_for_next_byte = 1'b0;
        repeat (g) @(negedge clock);
      end
    end
    check({tag, "_bad_bytes"}, bad, 0);
    check({tag, "_done_pulses"}, done_count - d0, 1);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    int          first, d0;

    reset = 1'b1;
    cmd_sector = '0; cmd_read = 1'b0; cmd_write = 1'b0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    sd_ready = 1'b1; sd_dout = '0; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_sd_address", sd_address, 0);
    check("rst_sd_din", sd_din, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    @(negedge clock);

    // Command while the controller is not ready is dropped.
    sd_ready = 1'b0; cmd_sector = 32'd5; cmd_read = 1'b1;
    @(negedge clock);
    cmd_read = 1'b0;
    check("notready_busy", busy, 0);
    check("notready_sd_rd", sd_rd, 0);
    repeat (3) @(negedge clock);
    check("notready_busy_later", busy, 0);
    sd_ready = 1'b1;
    @(negedge clock);

    // Patterned read of sector 3.
    xfer_read(32'd3, 1'b1, 1'b0, 1'b0, SECTOR_BYTES, "rd_pattern");
    check("rd_pattern_addr_const", sd_address, 32'h0000_0600);
    cpu_read(0, w);   check("rd_pattern_word0", w, 32'h0302_0100);
    cpu_read(127, w); check("rd_pattern_word127", w, 32'hFFFE_FDFC);
    check_buffer("rd_pattern");

    // CPU fills words, then a write drains them; a CPU write mid-transfer is ignored.
    cpu_write(0, 32'hDEAD_BEEF);
    cpu_write(127, 32'h1122_3344);
    repeat (6) cpu_write(int'($urandom_range(1, 126)), $urandom);
    xfer_write($urandom_range(0, 4095), 1'b1, "wr");
    check_buffer("wr_after");

    // Simultaneous read/write command: read wins; busy commands and CPU writes ignored.
    xfer_read($urandom_range(0, 4095), 1'b0, 1'b1, 1'b1, SECTOR_BYTES, "rd_collide");
    check_buffer("rd_collide");

    // Controller stalls after 10 bytes.
    d0 = done_count;
    xfer_read(32'd77, 1'b0, 1'b0, 1'b0, 9, "rd_timeout");
    b = 8'($urandom);
    ref_mem[9] = b;
    sd_dout = b;
    sd_byte_available = 1'b1;
    first = -1;
    for (int c = 1; c <= 300 && first < 0; c++) begin
      @(negedge clock);
      if (c == 3) sd_byte_available = 1'b0;
      if (error) first = c;
    end
    check("timeout_latency", first, 101);
    check("timeout_busy", busy, 0);
    check("timeout_sd_rd", sd_rd, 0);
    check("timeout_no_done", done_count - d0, 0);
    sd_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("timeout_error_sticky", error, 1);
    sd_ready = 1'b0; cmd_read = 1'b1;
    @(negedge clock);
    cmd_read = 1'b0;
    check("timeout_notready_busy", busy, 0);
    check("timeout_notready_error", error, 1);
    sd_ready = 1'b1;
    check_buffer("timeout_partial");

    // Next accepted read clears the error; reset while requesting drops sd_rd.
    cmd_sector = 32'd9; cmd_read = 1'b1;
    @(negedge clock);
    cmd_read = 1'b0;
    check("reaccept_error_clear", error, 0);
    check("reaccept_sd_rd", sd_rd, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_req_sd_rd", sd_rd, 0);
    check("rst_req_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset after 200 bytes of a read, then a complete read.
    xfer_read($urandom_range(0, 4095), 1'b0, 1'b0, 1'b0, 200, "rd_reset");
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sd_rd", sd_rd, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_sd_address", sd_address, 0);
    reset = 1'b0;
    sd_ready = 1'b1;
    @(negedge clock);
    check_buffer("rst_mid_partial");
    xfer_read($urandom_range(0, 4095), 1'b0, 1'b0, 1'b0, SECTOR_BYTES, "rd_after_reset");
    check_buffer("rd_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
- Upstream of the SPI SD-card byte interface.
- Accepts sector read/write commands from the MIPS core's memory-mapped I/O.
- Drives the SD controller's byte-level handshake (rd/wr, address, byte strobes) and holds one 512-byte sector in a local buffer.
- The core accesses the buffer as 128 little-endian 32-bit words.

Parameters:
- SECTOR_BYTES, 512: bytes per transfer; must be a multiple of 4.
- ADDR_SHIFT, 9: sd_address = cmd_sector << ADDR_SHIFT (9 for byte-addressed cards, 0 for SDHC).
- TIMEOUT_CYCLES, 2000000: max clocks without handshake progress before abort.

Ports:
- clock  in  1  system clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- cmd_sector  in  32  sector number, sampled when a command is accepted.
- cmd_read  in  1  pulse: fetch sector into buffer.
- cmd_write  in  1  pulse: write buffer to sector.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  timeout flag; sticky until the next accepted command.
- cpu_addr  in  7  word index into buffer.
- cpu_we  in  1  word write enable.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, registered.
- sd_ready  in  1  controller idle and able to accept a command.
- sd_address  out  32  block address to controller.
- sd_rd  out  1  read-block request.
- sd_wr  out  1  write-block request.
- sd_dout  in  8  byte from controller.
- sd_byte_available  in  1  sd_dout valid (level; may stay high several cycles).
- sd_din  out  8  byte to controller.
- sd_ready_for_next_byte  in  1  controller consumed sd_din (level).

Behaviour:
- Reset values:
  - busy=0, done=0, error=0, sd_rd=0, sd_wr=0.
  - sd_address=0, sd_din=0, cpu_rdata=0.
  - FSM in IDLE; byte counter=0; timeout counter=0.
  - Buffer contents are not cleared.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, FINISH.
- IDLE:
  - cmd_read with sd_ready=1 -> latch sd_address, clear error -> RD_REQ.
  - cmd_write with sd_ready=1 -> latch sd_address, clear error -> WR_REQ.
  - Both asserted: read wins.
  - Command while sd_ready=0 is ignored, with no flag.
- busy=1 in every state except IDLE.
- RD_REQ: hold sd_rd=1 until sd_ready is sampled 0, then sd_rd=0 -> RD_DATA.
- RD_DATA:
  - A byte is captured on each 0->1 transition of sd_byte_available (registered edge detect). The level alone never captures.
  - Byte k is stored at word k/4, bits [8*(k%4)+7 : 8*(k%4)].
  - After byte SECTOR_BYTES-1 is captured -> FINISH.
- WR_REQ:
  - sd_din is preloaded with byte 0.
  - Hold sd_wr=1 until sd_ready is sampled 0, then sd_wr=0 -> WR_DATA.
- WR_DATA:
  - On each 0->1 transition of sd_ready_for_next_byte, the byte counter increments and sd_din shows the next byte on the following cycle.
  - After the edge consuming byte SECTOR_BYTES-1 -> FINISH.
- FINISH:
  - Wait for sd_ready=1.
  - Then done=1 for exactly one cycle -> IDLE.
- Timeout:
  - The counter resets on every state change and every byte edge; otherwise it increments in non-IDLE states.
  - At TIMEOUT_CYCLES: error=1, sd_rd=sd_wr=0, no done pulse -> IDLE.
  - Buffer holds whatever bytes were already received.
- CPU port:
  - cpu_rdata = buffer[cpu_addr], registered; 1-cycle latency; always allowed, including mid-transfer partial data.
  - cpu_we is honoured only in IDLE; ignored while busy.
- Commands arriving while busy are ignored.
- Reset mid-transfer: immediate return to IDLE with reset values; controller-side requests drop the same cycle.

Test Plan:
1. Read: cmd_sector=3, ADDR_SHIFT=9 -> sd_address=0x600, sd_rd high until sd_ready=0. Model sends bytes 0x00..0xFF,0x00..0xFF with 3-cycle-wide byte_available -> exactly 512 captures, word0=0x03020100, word127=0xFFFEFDFC, one done pulse, busy low next cycle.
2. Write: CPU writes word0=0xDEADBEEF, word127=0x11223344, cmd_write -> model receives first bytes EF,BE,AD,DE and last bytes 44,33,22,11, 512 bytes total, done pulse.
3. Timeout (TIMEOUT_CYCLES=100): read command, model stops after 10 bytes -> after 100 idle cycles error=1, sd_rd=0, busy=0, no done. Next accepted cmd_read clears error.
4. Collisions: cmd_read and cmd_write in the same cycle -> only sd_rd asserts. cmd_read while busy is ignored; byte count still 512. cpu_we while busy leaves buffer unchanged.
5. Reset at byte 200 of a read -> next cycle busy=0, sd_rd=0, done=0. A new read then completes normally with 512 bytes.
6. cmd_read with sd_ready=0 -> no state change, busy stays 0.
